vga_frame_streamer: RTL



---
 rtl/vga_frame_streamer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vga_frame_streamer.sv
// vga_frame_streamer
//   Reads RGB444 pixels in raster order from a frame buffer with a 1-cycle
//   synchronous read port and emits one Avalon-ST packet per frame.
//
// Ports
//   clk, reset        : system clock, asynchronous active-high reset
//   enable            : level, streaming permitted while high (sampled in IDLE
//                       and on DRAIN exit only)
//   rd_addr, rd_en    : frame-buffer read request
//   rd_data           : frame-buffer read data, valid 1 cycle after rd_en
//   src_data/valid/sop/eop, src_ready : Avalon-ST video source
//   frame_done        : 1-cycle pulse when the EOP beat is accepted
//   busy              : high from the first read of a frame until EOP accepted
module vga_frame_streamer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LP_LAST    = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam int unsigned       LP_ENTRY_W = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_W-1:0]     r_addr;
  logic                  r_inflight;
  logic                  r_tag_sop;
  logic                  r_tag_eop;

  // 2-entry output FIFO, entry = {data, sop, eop}
  logic [LP_ENTRY_W-1:0] r_fifo [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic [LP_ENTRY_W-1:0] w_head;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_level;
  logic                  w_last;
  logic                  w_rd_en;
  logic                  w_frame_done;

  assign w_head  = r_fifo[r_rptr];
  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & src_ready;
  assign w_push  = r_inflight;
  assign w_last  = (r_addr == LP_LAST);

  // Occupancy a new read will find when it lands: entries left after this
  // cycle's pop plus the read already in flight. Crediting the pop is what
  // allows one read per clock while downstream keeps up; a read issued now
  // still fits even if src_ready drops next cycle.
  assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en      = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_rd_en = (w_level < 3'd2);
        if (w_rd_en && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && w_head[0]) begin
          w_frame_done = 1'b1;
          w_state_nxt  = enable ? S_RUN : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_tag_sop  <= 1'b0;
      r_tag_eop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      r_tag_sop  <= w_rd_en && (r_addr == '0);
      r_tag_eop  <= w_rd_en && w_last;
      if (w_rd_en) r_addr <= w_last ? '0 : r_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {rd_data, r_tag_sop, r_tag_eop};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_addr    = r_addr;
  assign rd_en      = w_rd_en;
  assign src_valid  = w_valid;
  assign src_data   = w_valid ? w_head[LP_ENTRY_W-1:2] : '0;
  assign src_sop    = w_valid & w_head[1];
  assign src_eop    = w_valid & w_head[0];
  assign frame_done = w_frame_done;
  assign busy       = (r_state != S_IDLE) && !w_frame_done;

endmodule
